// File: rtl/galaga_rom_loader_if.sv
// Buffered ROM write port between the download sequencer and the ROM stores.
// The master presents one byte at a time; the store takes it with wr_ack.
interface galaga_rom_loader_if;
    logic        wr_req;
    logic        wr_ack;
    logic [3:0]  wr_sel;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output wr_req,
        output wr_sel,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_sel,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/galaga_rom_loader.sv
// Download sequencer: routes ioctl bytes into four ROM regions through a
// one-entry write buffer and keeps the core in reset until the image settles.
//
// state | meaning
// IDLE  | after power-up, core held in reset, waiting for a download
// LOAD  | download active, bytes accepted into the write buffer
// DRAIN | download ended, waiting for the last buffered byte to be taken
// HOLD  | settle period before the core is released
// RUN   | core running, image loaded
module galaga_rom_loader #(
    parameter logic [16:0] B1          = 17'h04000,
    parameter logic [16:0] B2          = 17'h06000,
    parameter logic [16:0] B3          = 17'h07000,
    parameter logic [17:0] END         = 18'h09000,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       dn_download,
    input  logic                       dn_wr,
    input  logic [16:0]                dn_addr,
    input  logic [7:0]                 dn_data,
    galaga_rom_loader_if.master        wr,
    output logic                       core_reset,
    output logic                       loaded,
    output logic                       err_overrun,
    output logic                       err_range,
    output logic                       err_short
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_dl_prev;
    logic          w_rise;
    logic          w_enter_load;
    logic          w_drain_done;

    logic          r_wr_req;
    logic [3:0]    r_wr_sel;
    logic [16:0]   r_wr_addr;
    logic [7:0]    r_wr_data;

    logic [17:0]   r_count;
    logic [HW-1:0] r_hold_cnt;

    logic          w_in_range;
    logic          w_load_wr;
    logic          w_accept;
    logic          w_overrun;
    logic          w_range_drop;
    logic [3:0]    w_sel;
    logic [16:0]   w_base;

    assign w_rise = dn_download & ~r_dl_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dl_prev <= dn_download;
        end
    end

    // A new download rise wins over drain completion and hold expiry.
    always_comb begin
        w_state_next = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_next = S_LOAD;
            S_LOAD:  if (!dn_download) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (w_rise) begin
                    w_state_next = S_LOAD;
                end else if (!r_wr_req) begin
                    w_state_next = S_HOLD;
                    w_drain_done = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_rise) w_state_next = S_LOAD;
                else if (r_hold_cnt == '0) w_state_next = S_RUN;
            end
            S_RUN:   if (w_rise) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
        w_enter_load = (w_state_next == S_LOAD) && (r_state != S_LOAD);
    end

    always_comb begin
        w_sel  = 4'b1000;
        w_base = B3;
        if (dn_addr < B1) begin
            w_sel  = 4'b0001;
            w_base = '0;
        end else if (dn_addr < B2) begin
            w_sel  = 4'b0010;
            w_base = B1;
        end else if (dn_addr < B3) begin
            w_sel  = 4'b0100;
            w_base = B2;
        end
    end

    assign w_in_range   = {1'b0, dn_addr} < END;
    assign w_load_wr    = (r_state == S_LOAD) && dn_wr;
    assign w_accept     = w_load_wr && w_in_range && (!r_wr_req || wr.wr_ack);
    assign w_overrun    = w_load_wr && w_in_range && r_wr_req && !wr.wr_ack;
    assign w_range_drop = w_load_wr && !w_in_range;

    // Fields only change on accept, so they stay stable until acknowledged.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_req  <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_req  <= 1'b1;
            r_wr_sel  <= w_sel;
            r_wr_addr <= dn_addr - w_base;
            r_wr_data <= dn_data;
        end else if (r_wr_req && wr.wr_ack) begin
            r_wr_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_enter_load) begin
            r_count <= '0;
        end else if (w_accept && (r_count != '1)) begin
            r_count <= r_count + 18'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun <= 1'b0;
            err_range   <= 1'b0;
            err_short   <= 1'b0;
        end else if (w_enter_load) begin
            err_overrun <= 1'b0;
            err_range   <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            if (w_overrun)    err_overrun <= 1'b1;
            if (w_range_drop) err_range   <= 1'b1;
            if (w_drain_done && (r_count < END)) err_short <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if (w_drain_done) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    // Registered off the state so release and loaded move on the same edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
            loaded     <= 1'b0;
        end else begin
            core_reset <= (r_state != S_RUN);
            if (w_enter_load) loaded <= 1'b0;
            else if (r_state == S_RUN) loaded <= 1'b1;
        end
    end

    assign wr.wr_req  = r_wr_req;
    assign wr.wr_sel  = r_wr_sel;
    assign wr.wr_addr = r_wr_addr;
    assign wr.wr_data = r_wr_data;

endmodule
